// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and constants for the arbitro_wrr weighted round-robin scheduler.
//   arb_state_e  : transfer FSM states (IDLE -> POP -> CAPT -> WAIT -> IDLE)
//   CLASS_*/DEST_* : bit positions of the class and destination fields in a
//                    default-width word (offsets are applied for other widths)
//   W*_DEF       : default per-queue weights
//   eff_weight() : maps a configured weight onto its 3-bit effective value
// -----------------------------------------------------------------------------
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POP  = 2'd1,
      CAPT = 2'd2,
      WAIT = 2'd3
   } arb_state_e;

   localparam int WORD_SIZE_DEF = 12;
   localparam int CLASS_HI      = WORD_SIZE_DEF - 1;
   localparam int CLASS_LO      = WORD_SIZE_DEF - 2;
   localparam int DEST_HI       = WORD_SIZE_DEF - 3;
   localparam int DEST_LO       = WORD_SIZE_DEF - 4;

   localparam int unsigned W0_DEF = 4;
   localparam int unsigned W1_DEF = 3;
   localparam int unsigned W2_DEF = 2;
   localparam int unsigned W3_DEF = 1;

   // Weights live in a 3-bit range; a zero weight would starve its own queue,
   // so it is promoted to a single grant.
   function automatic logic [2:0] eff_weight(input int unsigned w);
      logic [2:0] w3;
      w3 = 3'(w);
      return (w3 == 3'd0) ? 3'd1 : w3;
   endfunction

endpackage

// File: rtl/wrr_select.sv
// -----------------------------------------------------------------------------
// wrr_select
// Grant pointer and credit counter of the weighted round-robin scheduler.
// Ports:
//   clk, reset    : clock, synchronous active-low reset
//   fifos_empty   : empty flags of input queues 0..3
//   eligible      : the FSM may issue a new grant this cycle
//   advance       : commit the offered grant (update grant_q / credit)
//   grant         : queue that would be granted this cycle
//   valid         : grant is meaningful (eligible and a queue is non-empty)
//   grant_q       : last committed grant
// -----------------------------------------------------------------------------
module wrr_select
   import arb_pkg::*;
#(
   parameter int unsigned W0 = W0_DEF,
   parameter int unsigned W1 = W1_DEF,
   parameter int unsigned W2 = W2_DEF,
   parameter int unsigned W3 = W3_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] fifos_empty,
   input  logic       eligible,
   input  logic       advance,
   output logic [1:0] grant,
   output logic       valid,
   output logic [1:0] grant_q
);

   logic [1:0] grant_d;
   logic [2:0] credit_q;
   logic [2:0] credit_d;
   logic [2:0] credit_nxt;
   logic [1:0] cand;
   logic       found;

   function automatic logic [2:0] weight_of(input logic [1:0] q);
      case (q)
         2'd0:    weight_of = eff_weight(W0);
         2'd1:    weight_of = eff_weight(W1);
         2'd2:    weight_of = eff_weight(W2);
         default: weight_of = eff_weight(W3);
      endcase
   endfunction

   // Remaining credit keeps the current queue; an empty current queue falls
   // through to the rotation scan and thereby forfeits whatever credit it had.
   // The scan visits grant_q last (k == 4 wraps to +0).
   always_comb begin
      // NOTE: every variable gets a default before any branch so no path
      // leaves it unassigned, which would otherwise infer a latch.
      grant      = grant_q;
      credit_nxt = credit_q;
      found      = 1'b0;
      cand       = grant_q;
      if (!fifos_empty[grant_q] && credit_q != 3'd0) begin
         found      = 1'b1;
         credit_nxt = credit_q - 3'd1;
      end else begin
         for (int k = 1; k <= 4; k++) begin
            cand = grant_q + 2'(k);
            if (!found && !fifos_empty[cand]) begin
               found      = 1'b1;
               grant      = cand;
               credit_nxt = weight_of(cand) - 3'd1;
            end
         end
      end
      valid = eligible && found;
   end

   always_comb begin
      grant_d  = grant_q;
      credit_d = credit_q;
      if (advance) begin
         grant_d  = grant;
         credit_d = credit_nxt;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      if (!reset) begin
         grant_q  <= 2'd3;
         credit_q <= 3'd0;
      end else begin
         grant_q  <= grant_d;
         credit_q <= credit_d;
      end
   end

endmodule

// File: rtl/arbitro_wrr.sv
// -----------------------------------------------------------------------------
// arbitro_wrr
// Weighted round-robin scheduler moving words from four input class FIFOs to
// four output destination FIFOs. Word: [11:10] class, [9:8] dest, [7:0] data.
// Build option: ARB_PERPORT_STALL_EN -- when defined, only the destination of
// a captured word can stall the transfer; when undefined, any almost-full
// output blocks new grants.
// Ports:
//   clk, reset           : clock, synchronous active-low reset
//   fifos_empty          : empty flags of input FIFOs 0..3
//   fifos_almost_full    : almost-full flags of output FIFOs 0..3
//   fifo_data_in0..3     : input FIFO read data, valid the cycle after a pop
//   fifos_pop            : one-hot pop pulse to the input FIFOs
//   fifos_push           : one-hot push pulse to the output FIFOs
//   fifo_data_out_cond   : pushed word, zero in every non-push cycle
//   grant_q              : last granted input queue
//   arb_busy             : high while a transfer is in flight (state != IDLE)
// -----------------------------------------------------------------------------
module arbitro_wrr
   import arb_pkg::*;
#(
   parameter int          WORD_SIZE = WORD_SIZE_DEF,
   parameter int unsigned W0        = W0_DEF,
   parameter int unsigned W1        = W1_DEF,
   parameter int unsigned W2        = W2_DEF,
   parameter int unsigned W3        = W3_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [3:0]           fifos_empty,
   input  logic [3:0]           fifos_almost_full,
   input  logic [WORD_SIZE-1:0] fifo_data_in0,
   input  logic [WORD_SIZE-1:0] fifo_data_in1,
   input  logic [WORD_SIZE-1:0] fifo_data_in2,
   input  logic [WORD_SIZE-1:0] fifo_data_in3,
   output logic [3:0]           fifos_pop,
   output logic [3:0]           fifos_push,
   output logic [WORD_SIZE-1:0] fifo_data_out_cond,
   output logic [1:0]           grant_q,
   output logic                 arb_busy
);

   // Field positions track the top of the word when WORD_SIZE is overridden.
   localparam int DSH = WORD_SIZE - WORD_SIZE_DEF;

   arb_state_e           state_q, state_d;
   logic [3:0]           pop_q, pop_d;
   logic [3:0]           push_q, push_d;
   logic [WORD_SIZE-1:0] out_q, out_d;
   logic [WORD_SIZE-1:0] hold_q, hold_d;
   logic                 busy_q, busy_d;
   logic [WORD_SIZE-1:0] data_sel;
   logic [1:0]           grant;
   logic [1:0]           dest;
   logic                 eligible;
   logic                 valid;

   assign dest = hold_q[DEST_HI+DSH : DEST_LO+DSH];

`ifdef ARB_PERPORT_STALL_EN
   assign eligible = (state_q == IDLE);
`else
   assign eligible = (state_q == IDLE) && (fifos_almost_full == 4'b0000);
`endif

   wrr_select #(
      .W0 (W0),
      .W1 (W1),
      .W2 (W2),
      .W3 (W3)
   ) u_sel (
      .clk         (clk),
      .reset       (reset),
      .fifos_empty (fifos_empty),
      .eligible    (eligible),
      .advance     (valid),
      .grant       (grant),
      .valid       (valid),
      .grant_q     (grant_q)
   );

   always_comb begin
      case (grant_q)
         2'd0:    data_sel = fifo_data_in0;
         2'd1:    data_sel = fifo_data_in1;
         2'd2:    data_sel = fifo_data_in2;
         default: data_sel = fifo_data_in3;
      endcase
   end

   // Pop and push pulses are one-cycle strobes; the push of a word shares its
   // IDLE cycle with the next grant decision, so pop and push never overlap.
   always_comb begin
      state_d = state_q;
      pop_d   = 4'b0000;
      push_d  = 4'b0000;
      out_d   = '0;
      hold_d  = hold_q;
      case (state_q)
         IDLE: begin
            if (valid) begin
               state_d = POP;
               pop_d   = 4'b0001 << grant;
            end
         end
         POP:  state_d = CAPT;
         CAPT: begin
            hold_d  = data_sel;
            state_d = WAIT;
         end
         WAIT: begin
            if (!fifos_almost_full[dest]) begin
               state_d = IDLE;
               push_d  = 4'b0001 << dest;
               out_d   = hold_q;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         pop_q   <= 4'b0000;
         push_q  <= 4'b0000;
         out_q   <= '0;
         hold_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pop_q   <= pop_d;
         push_q  <= push_d;
         out_q   <= out_d;
         hold_q  <= hold_d;
         busy_q  <= busy_d;
      end
   end

   assign fifos_pop          = pop_q;
   assign fifos_push         = push_q;
   assign fifo_data_out_cond = out_q;
   assign arb_busy           = busy_q;

endmodule

// File: tb/tb_arbitro_wrr.sv
// -----------------------------------------------------------------------------
// tb_arbitro_wrr
// Self-checking bench for arbitro_wrr: directed timing scenarios plus
// randomized queue loads compared against a queue-level WRR model.
// -----------------------------------------------------------------------------
module tb_arbitro_wrr;
   import arb_pkg::*;

   localparam int WS = 12;

   typedef struct {
      logic [1:0]    port;
      logic [WS-1:0] data;
      int            cyc;
   } push_t;

   logic          clk      = 1'b0;
   logic          reset    = 1'b0;
   logic [3:0]    empty_r  = 4'hF;
   logic [3:0]    af       = 4'h0;
   logic [WS-1:0] rd_data [4];
   logic [3:0]    fifos_pop;
   logic [3:0]    fifos_push;
   logic [WS-1:0] data_out;
   logic [1:0]    grant_q;
   logic          arb_busy;

   int n_tests       = 0;
   int n_fail        = 0;
   int bad_cnt       = 0;
   int pop_empty_cnt = 0;
   int cyc           = 0;
   int base_g        = 0;
   int base_p        = 0;

   // Load requests (main process) consumed by the FIFO model process.
   logic [WS-1:0] ld_word [512];
   int            ld_qi   [512];
   int            ld_cnt   = 0;
   int            ld_taken = 0;

   logic [WS-1:0] in_q  [4][$];
   logic [WS-1:0] exp_q [4][$];
   int            exp_grant[$];
   logic [WS-1:0] exp_word[$];
   int            grant_log[$];
   push_t         push_log[$];
   int            wt [4] = '{4, 3, 2, 1};

   arbitro_wrr dut (
      .clk                (clk),
      .reset              (reset),
      .fifos_empty        (empty_r),
      .fifos_almost_full  (af),
      .fifo_data_in0      (rd_data[0]),
      .fifo_data_in1      (rd_data[1]),
      .fifo_data_in2      (rd_data[2]),
      .fifo_data_in3      (rd_data[3]),
      .fifos_pop          (fifos_pop),
      .fifos_push         (fifos_push),
      .fifo_data_out_cond (data_out),
      .grant_q            (grant_q),
      .arb_busy           (arb_busy)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] oh2idx(input logic [3:0] v);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 3; i >= 0; i--) if (v[i]) r = 2'(i);
      return r;
   endfunction

   // Input FIFO model: read data appears the cycle after the pop.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (fifos_pop[i]) begin
            if (in_q[i].size() == 0) pop_empty_cnt++;
            else rd_data[i] <= in_q[i].pop_front();
         end
      end
      while (ld_taken < ld_cnt) begin
         in_q[ld_qi[ld_taken]].push_back(ld_word[ld_taken]);
         ld_taken++;
      end
      for (int i = 0; i < 4; i++) empty_r[i] <= (in_q[i].size() == 0);
   end

   // Output monitor, sampled away from the active edge.
   always @(negedge clk) begin
      push_t p;
      cyc++;
      if (fifos_pop != 4'd0) begin
         if (!$onehot(fifos_pop) || fifos_push != 4'd0) bad_cnt++;
         grant_log.push_back(int'(oh2idx(fifos_pop)));
      end
      if (fifos_push != 4'd0) begin
         if (!$onehot(fifos_push)) bad_cnt++;
         p.port = oh2idx(fifos_push);
         p.data = data_out;
         p.cyc  = cyc;
         push_log.push_back(p);
      end else if (data_out != '0) begin
         bad_cnt++;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WS-1:0] mk_word(input int cls, input int dst, input int dat);
      logic [WS-1:0] w;
      w = '0;
      w[CLASS_HI:CLASS_LO] = 2'(cls);
      w[DEST_HI:DEST_LO]   = 2'(dst);
      w[7:0]               = 8'(dat);
      return w;
   endfunction

   task automatic load(input int qi, input logic [WS-1:0] w);
      ld_qi[ld_cnt]   = qi;
      ld_word[ld_cnt] = w;
      ld_cnt++;
      exp_q[qi].push_back(w);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      af    = 4'h0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) exp_q[i].delete();
      base_g = grant_log.size();
      base_p = push_log.size();
   endtask

   // Queue-level model: starting after the last served queue, pick the next
   // non-empty queue and serve min(weight, backlog) words from it in a row.
   task automatic build_expect();
      int last, q, n, total;
      bit found;
      exp_grant.delete();
      exp_word.delete();
      last = 3;
      q    = 0;
      total = exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
      while (total > 0) begin
         found = 1'b0;
         for (int k = 1; k <= 4 && !found; k++) begin
            q = (last + k) % 4;
            if (exp_q[q].size() > 0) found = 1'b1;
         end
         n = (exp_q[q].size() < wt[q]) ? exp_q[q].size() : wt[q];
         repeat (n) begin
            exp_grant.push_back(q);
            exp_word.push_back(exp_q[q].pop_front());
         end
         total -= n;
         last = q;
      end
   endtask

   task automatic run_and_compare(input string tag, input int budget);
      int n, c;
      logic [WS-1:0] w;
      build_expect();
      n = exp_word.size();
      c = 0;
      while (push_log.size() - base_p < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      repeat (8) @(negedge clk);
      check({tag, "_npush"}, push_log.size() - base_p, n);
      check({tag, "_ngrant"}, grant_log.size() - base_g, n);
      for (int i = 0; i < n; i++) begin
         w = exp_word[i];
         if (base_g + i < grant_log.size())
            check({tag, "_grant"}, grant_log[base_g + i], exp_grant[i]);
         if (base_p + i < push_log.size()) begin
            check({tag, "_port"}, push_log[base_p + i].port, w[DEST_HI:DEST_LO]);
            check({tag, "_data"}, push_log[base_p + i].data, w);
         end
      end
   endtask

   initial begin
      int c;
      int cnt [4];

      // Reset state
      do_reset();
      check("rst_pop", fifos_pop, 4'b0000);
      check("rst_push", fifos_push, 4'b0000);
      check("rst_data", data_out, 0);
      check("rst_grant_q", grant_q, 2'd3);
      check("rst_busy", arb_busy, 1'b0);

      // Single word latency: pop at t+1, push at t+4
      do_reset();
      load(2, 12'h2A5);
      c = 0;
      while (empty_r[2] && c < 10) begin @(negedge clk); c++; end
      check("sw_empty_fell", empty_r[2], 1'b0);
      check("sw_t_pop", fifos_pop, 4'b0000);
      @(negedge clk);
      check("sw_t1_pop", fifos_pop, 4'b0100);
      check("sw_t1_grant_q", grant_q, 2'd2);
      check("sw_t1_busy", arb_busy, 1'b1);
      @(negedge clk);
      check("sw_t2_pop", fifos_pop, 4'b0000);
      @(negedge clk);
      check("sw_t3_push", fifos_push, 4'b0000);
      check("sw_t3_busy", arb_busy, 1'b1);
      @(negedge clk);
      check("sw_t4_push", fifos_push, 4'b0100);
      check("sw_t4_data", data_out, 12'h2A5);
      check("sw_t4_busy", arb_busy, 1'b0);
      @(negedge clk);
      check("sw_t5_push", fifos_push, 4'b0000);
      check("sw_t5_data", data_out, 0);

      // Reset asserted during CAPT discards the captured word
      do_reset();
      load(0, mk_word(0, 3, 8'h77));
      c = 0;
      while (fifos_pop == 4'd0 && c < 20) begin @(negedge clk); c++; end
      check("rm_pop", fifos_pop, 4'b0001);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rm_pop0", fifos_pop, 4'b0000);
      check("rm_push0", fifos_push, 4'b0000);
      check("rm_data0", data_out, 0);
      check("rm_busy0", arb_busy, 1'b0);
      check("rm_grant_q", grant_q, 2'd3);
      reset = 1'b1;
      repeat (12) @(negedge clk);
      check("rm_no_push", push_log.size() - base_p, 0);
      check("rm_one_pop", grant_log.size() - base_g, 1);

      // WRR order with 12 random words per queue
      do_reset();
      for (int q = 0; q < 4; q++)
         for (int i = 0; i < 12; i++)
            load(q, mk_word(q, $urandom_range(0, 3), $urandom_range(0, 255)));
      run_and_compare("wrr", 48 * 5 + 20);

      // Credit forfeit when the current queue runs dry
      do_reset();
      for (int i = 0; i < 2; i++) load(0, mk_word(0, $urandom_range(0, 3), $urandom_range(0, 255)));
      for (int i = 0; i < 5; i++) load(1, mk_word(1, $urandom_range(0, 3), $urandom_range(0, 255)));
      for (int i = 0; i < 5; i++) load(3, mk_word(3, $urandom_range(0, 3), $urandom_range(0, 255)));
      run_and_compare("forfeit", 12 * 5 + 20);

      // Destination stall holds the push until the flag drops
      do_reset();
      load(1, 12'h53C);
      c = 0;
      while (fifos_pop == 4'd0 && c < 20) begin @(negedge clk); c++; end
      check("ds_pop", fifos_pop, 4'b0010);
      af = 4'b0010;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("ds_held_push", fifos_push, 4'b0000);
         check("ds_held_busy", arb_busy, 1'b1);
      end
      af = 4'b0000;
      @(negedge clk);
      check("ds_push", fifos_push, 4'b0010);
      check("ds_data", data_out, 12'h53C);

      // Global vs per-port stall: port 3 almost full, traffic only to port 0
      do_reset();
      af = 4'b1000;
      for (int i = 0; i < 3; i++) load(0, mk_word(0, 0, $urandom_range(0, 255)));
`ifdef ARB_PERPORT_STALL_EN
      run_and_compare("pp", 3 * 5 + 20);
      if (push_log.size() - base_p >= 3) begin
         check("pp_gap1", push_log[base_p + 1].cyc - push_log[base_p].cyc, 4);
         check("pp_gap2", push_log[base_p + 2].cyc - push_log[base_p + 1].cyc, 4);
      end
      af = 4'b0000;
`else
      repeat (20) @(negedge clk);
      check("gs_no_pop", grant_log.size() - base_g, 0);
      check("gs_idle", arb_busy, 1'b0);
      af = 4'b0000;
      run_and_compare("gs", 3 * 5 + 20);
`endif

      // Randomized rounds against the model
      for (int r = 0; r < 3; r++) begin
         do_reset();
         for (int q = 0; q < 4; q++) begin
            cnt[q] = $urandom_range(0, 6);
            for (int i = 0; i < cnt[q]; i++)
               load(q, mk_word(q, $urandom_range(0, 3), $urandom_range(0, 255)));
         end
         run_and_compare("rnd", 24 * 5 + 20);
      end

      check("inv_onehot_exclusive", bad_cnt, 0);
      check("inv_no_pop_on_empty", pop_empty_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
